// File: rtl/bludger_if.sv
// bludger_if: game datapath bundle between the ball controller and its neighbours
interface bludger_if;
  logic       serve_button;
  logic [9:0] team1_ver_pos;
  logic [9:0] team2_ver_pos;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] team1_score;
  logic [3:0] team2_score;
  logic       goal;
  logic       game_over;
  logic [2:0] state;
  modport master (
    output serve_button, team1_ver_pos, team2_ver_pos,
    input  ball_x, ball_y, team1_score, team2_score, goal, game_over, state
  );
  modport slave (
    input  serve_button, team1_ver_pos, team2_ver_pos,
    output ball_x, ball_y, team1_score, team2_score, goal, game_over, state
  );
endinterface

// File: rtl/bludger_controller.sv
// bludger_controller: ball motion, bounces, goals, scores and serve/play/goal/over sequencing
module bludger_controller #(
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int BALL_RADIUS   = 8,
  parameter int PLAYER_RADIUS = 35,
  parameter int TEAM1_HOR_POS = 100,
  parameter int TEAM2_HOR_POS = 540,
  parameter int STEP_PERIOD   = 100000,
  parameter int SERVE_DELAY   = 60,
  parameter int WIN_SCORE     = 7
) (
  input logic clk,
  input logic rst_n,
  bludger_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, GOAL, OVER} state_t;
  localparam int SW = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam int DW = $clog2(SERVE_DELAY + 1);
  localparam logic [9:0] CX   = 10'(SCREEN_W / 2);
  localparam logic [9:0] CY   = 10'(SCREEN_H / 2);
  localparam logic [9:0] HIT1 = 10'(TEAM1_HOR_POS + PLAYER_RADIUS + BALL_RADIUS);
  localparam logic [9:0] HIT2 = 10'(TEAM2_HOR_POS - PLAYER_RADIUS - BALL_RADIUS);
  localparam logic [9:0] LO   = 10'(BALL_RADIUS);
  localparam logic [9:0] GR   = 10'(SCREEN_W - 1 - BALL_RADIUS);
  localparam logic [9:0] YB   = 10'(SCREEN_H - 1 - BALL_RADIUS);
  state_t st;
  logic [SW-1:0] scnt;
  logic [DW-1:0] dcnt;
  logic dx_neg, dy_neg, nx_neg, ny_neg;
  logic tick, delay_done, hit1, hit2, goal_l, goal_r, won;
  logic signed [10:0] d1, d2, a1, a2;
  always_comb begin
    tick       = scnt == SW'(STEP_PERIOD - 1);
    delay_done = tick && dcnt == DW'(SERVE_DELAY - 1);
    d1         = $signed({1'b0, bus.ball_y}) - $signed({1'b0, bus.team1_ver_pos});
    d2         = $signed({1'b0, bus.ball_y}) - $signed({1'b0, bus.team2_ver_pos});
    a1         = d1 < 0 ? -d1 : d1;
    a2         = d2 < 0 ? -d2 : d2;
    hit1       = dx_neg && bus.ball_x == HIT1 && a1 <= $signed(11'(PLAYER_RADIUS));
    hit2       = !dx_neg && bus.ball_x == HIT2 && a2 <= $signed(11'(PLAYER_RADIUS));
    goal_l     = dx_neg && !hit1 && bus.ball_x == LO;
    goal_r     = !dx_neg && !hit2 && bus.ball_x == GR;
    nx_neg     = hit1 ? 1'b0 : hit2 ? 1'b1 : dx_neg;
    ny_neg     = (dy_neg && bus.ball_y == LO) ? 1'b0 : (!dy_neg && bus.ball_y == YB) ? 1'b1 : dy_neg;
    won        = bus.team1_score == 4'(WIN_SCORE) || bus.team2_score == 4'(WIN_SCORE);
  end
  assign bus.state = st;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st              <= IDLE;
      scnt            <= '0;
      dcnt            <= '0;
      dx_neg          <= 1'b0;
      dy_neg          <= 1'b0;
      bus.ball_x      <= CX;
      bus.ball_y      <= CY;
      bus.team1_score <= '0;
      bus.team2_score <= '0;
      bus.goal        <= 1'b0;
      bus.game_over   <= 1'b0;
    end else begin
      scnt     <= tick ? '0 : scnt + 1'b1;
      bus.goal <= 1'b0;
      case (st)
        IDLE: if (bus.serve_button) begin
          st   <= SERVE;
          dcnt <= '0;
        end
        SERVE: if (tick) begin
          dcnt <= delay_done ? '0 : dcnt + 1'b1;
          st   <= delay_done ? PLAY : SERVE;
        end
        PLAY: if (tick) begin
          if (goal_l || goal_r) begin
            st              <= GOAL;
            dcnt            <= '0;
            bus.goal        <= 1'b1;
            bus.team1_score <= bus.team1_score + 4'(goal_r);
            bus.team2_score <= bus.team2_score + 4'(goal_l);
            dx_neg          <= goal_r;
          end else begin
            dx_neg     <= nx_neg;
            dy_neg     <= ny_neg;
            bus.ball_x <= nx_neg ? bus.ball_x - 1'b1 : bus.ball_x + 1'b1;
            bus.ball_y <= ny_neg ? bus.ball_y - 1'b1 : bus.ball_y + 1'b1;
          end
        end
        GOAL: if (tick) begin
          dcnt <= delay_done ? '0 : dcnt + 1'b1;
          if (delay_done) begin
            st            <= won ? OVER : SERVE;
            bus.game_over <= won;
            dy_neg        <= won ? dy_neg : 1'b0;
            bus.ball_x    <= won ? bus.ball_x : CX;
            bus.ball_y    <= won ? bus.ball_y : CY;
          end
        end
        OVER: if (bus.serve_button) begin
          st              <= SERVE;
          dcnt            <= '0;
          dx_neg          <= 1'b0;
          dy_neg          <= 1'b0;
          bus.ball_x      <= CX;
          bus.ball_y      <= CY;
          bus.team1_score <= '0;
          bus.team2_score <= '0;
          bus.game_over   <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
